// File: rtl/n3_pkg.sv
// Shared definitions for the n3 compressor/decompressor family.
package n3_pkg;

   localparam int unsigned N_DEF         = 16;
   localparam int unsigned ADDR_SIZE_DEF = 16;
   localparam int unsigned CNT_W_DEF     = 16;
   // A stored pair occupies two SRAM words: value, then offset.
   localparam int unsigned PAIR_STRIDE   = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_VAL  = 3'd1,
      RD_OFF  = 3'd2,
      CAP_OFF = 3'd3,
      EMIT    = 3'd4,
      DONE    = 3'd5
   } state_e;

endpackage

// File: rtl/n3_decomp_if.sv
// Control, SRAM read port and dense output lane of one n3 decompressor.
interface n3_decomp_if
   import n3_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) ();

   logic                 i_start;
   logic [ADDR_SIZE-1:0] i_base_addr;
   logic [CNT_W-1:0]     i_nnz;
   logic [CNT_W-1:0]     i_len;
   logic                 o_rd_en;
   logic [ADDR_SIZE-1:0] o_rd_addr;
   logic [N-1:0]         i_rd_data;
   logic                 o_valid;
   logic                 i_ready;
   logic [N-1:0]         o_data;
   logic                 o_busy;
   logic                 o_done;
   logic                 o_err;

   modport slave (
      input  i_start, i_base_addr, i_nnz, i_len, i_rd_data, i_ready,
      output o_rd_en, o_rd_addr, o_valid, o_data, o_busy, o_done, o_err
   );

   modport master (
      output i_start, i_base_addr, i_nnz, i_len, i_rd_data, i_ready,
      input  o_rd_en, o_rd_addr, o_valid, o_data, o_busy, o_done, o_err
   );

endinterface

// File: rtl/n3_decomp.sv
// Expands a (value, offset) pair stream read from SRAM back into a dense lane,
// filling the gaps between stored offsets with zeros.
module n3_decomp
   import n3_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic          clk,
   input  logic          rst,
   n3_decomp_if.slave    bus
);

   localparam int unsigned CMP_W = (N > CNT_W) ? N : CNT_W;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] base_q, base_d;
   logic [ADDR_SIZE-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [CNT_W-1:0]     pos_q, pos_d;
   logic [CNT_W-1:0]     pairs_left_q, pairs_left_d;
   logic [N-1:0]         val_q, val_d;
   logic [N-1:0]         off_q, off_d;
   logic                 has_pair_q, has_pair_d;
   logic                 err_q, err_d;

   logic                 rd_en_q, rd_en_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 valid_q, valid_d;
   logic [N-1:0]         data_q, data_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 hit_q, stale_q;

   assign hit_q   = has_pair_q && (CMP_W'(off_q) == CMP_W'(pos_q));
   assign stale_q = has_pair_q && (CMP_W'(off_q) <  CMP_W'(pos_q));

   // Next-state and datapath update.
   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      idx_d        = idx_q;
      len_d        = len_q;
      pos_d        = pos_q;
      pairs_left_d = pairs_left_q;
      val_d        = val_q;
      off_d        = off_q;
      has_pair_d   = has_pair_q;
      err_d        = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               base_d       = bus.i_base_addr;
               len_d        = bus.i_len;
               pairs_left_d = bus.i_nnz;
               pos_d        = '0;
               idx_d        = '0;
               has_pair_d   = 1'b0;
               err_d        = 1'b0;
               if (bus.i_len == '0)      state_d = DONE;
               else if (bus.i_nnz == '0) state_d = EMIT;
               else                      state_d = RD_VAL;
            end
         end
         RD_VAL: state_d = RD_OFF;
         RD_OFF: begin
            val_d   = bus.i_rd_data;
            state_d = CAP_OFF;
         end
         CAP_OFF: begin
            off_d        = bus.i_rd_data;
            idx_d        = idx_q + ADDR_SIZE'(PAIR_STRIDE);
            pairs_left_d = pairs_left_q - CNT_W'(1);
            has_pair_d   = 1'b1;
            state_d      = EMIT;
         end
         EMIT: begin
            // A pair pointing behind the current position can never be placed.
            if (stale_q) begin
               err_d      = 1'b1;
               has_pair_d = 1'b0;
               if (pairs_left_q != '0) state_d = RD_VAL;
            end else if (valid_q && bus.i_ready) begin
               pos_d = pos_q + CNT_W'(1);
               if (hit_q) has_pair_d = 1'b0;
               if (pos_q == len_q - CNT_W'(1)) begin
                  state_d = DONE;
                  if (has_pair_q && !hit_q) err_d = 1'b1;
               end else if (hit_q && pairs_left_q != '0) begin
                  state_d = RD_VAL;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the cycle the FSM is about to enter.
   always_comb begin
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      valid_d   = 1'b0;
      data_d    = '0;
      busy_d    = (state_d != IDLE);
      done_d    = (state_d == DONE);
      if (state_d == RD_VAL) begin
         rd_en_d   = 1'b1;
         rd_addr_d = base_d + idx_d;
      end else if (state_d == RD_OFF) begin
         rd_en_d   = 1'b1;
         rd_addr_d = base_d + idx_d + ADDR_SIZE'(1);
      end else if (state_d == EMIT) begin
         valid_d = !(has_pair_d && (CMP_W'(off_d) < CMP_W'(pos_d)));
         if (has_pair_d && (CMP_W'(off_d) == CMP_W'(pos_d))) data_d = val_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         idx_q        <= '0;
         len_q        <= '0;
         pos_q        <= '0;
         pairs_left_q <= '0;
         val_q        <= '0;
         off_q        <= '0;
         has_pair_q   <= 1'b0;
         err_q        <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         pos_q        <= pos_d;
         pairs_left_q <= pairs_left_d;
         val_q        <= val_d;
         off_q        <= off_d;
         has_pair_q   <= has_pair_d;
         err_q        <= err_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign bus.o_rd_en   = rd_en_q;
   assign bus.o_rd_addr = rd_addr_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_data    = data_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_done    = done_q;
   assign bus.o_err     = err_q;

endmodule

// File: tb/tb_n3_decomp.sv
// Directed vector bench for n3_decomp with a behavioural SRAM and output monitor.
module tb_n3_decomp;
   import n3_pkg::*;

   localparam int unsigned N  = 16;
   localparam int unsigned AW = 16;
   localparam int unsigned CW = 16;

   typedef struct {
      logic [15:0]       base;
      logic [15:0]       nnz;
      logic [15:0]       len;
      logic [1:0][15:0]  val;
      logic [1:0][15:0]  off;
      int                n_out;
      logic [7:0][15:0]  exp;    // word i expected at exp[7-i]
      logic              exp_err;
      int                n_reads;
      bit                stall;
      bit                glitch;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   n3_decomp_if #(.N(N), .ADDR_SIZE(AW), .CNT_W(CW)) bus ();
   n3_decomp #(.N(N), .ADDR_SIZE(AW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [15:0] mem [0:65535];
   always @(posedge clk) bus.i_rd_data <= mem[bus.o_rd_addr];

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] outq[$];
   logic [15:0] rdq[$];
   int          done_cnt, valid_cnt, stall_err;
   bit          prev_stall;
   logic [15:0] prev_data;
   bit          stall_mode = 1'b0;
   int          rcyc = 0;

   // Ready pattern 1,0,0,1 repeating when stalling, else always ready.
   always @(posedge clk) begin
      #1;
      if (stall_mode) bus.i_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
      else            bus.i_ready = 1'b1;
      rcyc++;
   end

   always @(negedge clk) begin
      if (bus.o_valid && bus.i_ready) outq.push_back(bus.o_data);
      if (bus.o_valid)  valid_cnt++;
      if (bus.o_rd_en)  rdq.push_back(bus.o_rd_addr);
      if (bus.o_done)   done_cnt++;
      if (prev_stall && (!bus.o_valid || bus.o_data != prev_data)) stall_err++;
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_data  = bus.o_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] base, nnz, len, v0, o0, v1, o1,
                               input int n_out, input logic [7:0][15:0] e,
                               input logic err, input int nrd, input bit st, input bit gl);
      vec_t v;
      v.base = base; v.nnz = nnz; v.len = len;
      v.val[0] = v0; v.off[0] = o0; v.val[1] = v1; v.off[1] = o1;
      v.n_out = n_out; v.exp = e; v.exp_err = err; v.n_reads = nrd;
      v.stall = st; v.glitch = gl;
      return v;
   endfunction

   task automatic clear_mon();
      outq.delete();
      rdq.delete();
      done_cnt   = 0;
      valid_cnt  = 0;
      stall_err  = 0;
      prev_stall = 1'b0;
   endtask

   task automatic load_pairs(input vec_t v);
      logic [15:0] a;
      for (int k = 0; k < 2; k++) begin
         if (k < int'(v.nnz)) begin
            a = v.base + 16'(2 * k);
            mem[a] = v.val[k];
            a = a + 16'd1;
            mem[a] = v.off[k];
         end
      end
   endtask

   task automatic do_start(input logic [15:0] base, nnz, len);
      @(posedge clk); #2;
      bus.i_start = 1'b1; bus.i_base_addr = base; bus.i_nnz = nnz; bus.i_len = len;
      @(posedge clk); #2;
      bus.i_start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int          t;
      logic [15:0] ea;
      load_pairs(v);
      clear_mon();
      stall_mode = v.stall;
      do_start(v.base, v.nnz, v.len);
      if (v.glitch) begin
         repeat (2) @(posedge clk);
         #2;
         bus.i_start = 1'b1; bus.i_base_addr = 16'h9999; bus.i_nnz = 16'd0; bus.i_len = 16'd1;
         @(posedge clk); #2;
         bus.i_start = 1'b0;
      end
      t = 0;
      while (done_cnt == 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      chk($sformatf("v%0d_done_seen", id), 32'(done_cnt != 0), 32'd1);
      repeat (4) @(posedge clk);
      #2;
      chk($sformatf("v%0d_done_count", id), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_out_count", id), 32'(outq.size()), 32'(v.n_out));
      for (int i = 0; i < v.n_out; i++)
         if (i < outq.size())
            chk($sformatf("v%0d_word%0d", id, i), 32'(outq[i]), 32'(v.exp[7-i]));
      chk($sformatf("v%0d_err", id), 32'(bus.o_err), 32'(v.exp_err));
      chk($sformatf("v%0d_read_count", id), 32'(rdq.size()), 32'(v.n_reads));
      for (int i = 0; i < v.n_reads; i++) begin
         ea = v.base + 16'(i);
         if (i < rdq.size()) chk($sformatf("v%0d_raddr%0d", id, i), 32'(rdq[i]), 32'(ea));
      end
      chk($sformatf("v%0d_stall_hold", id), 32'(stall_err), 32'd0);
      chk($sformatf("v%0d_busy_end", id), 32'(bus.o_busy), 32'd0);
      if (v.n_out == 0) chk($sformatf("v%0d_no_valid", id), 32'(valid_cnt), 32'd0);
      stall_mode = 1'b0;
   endtask

   vec_t vt[9];

   initial begin
      int t;
      bit found;
      for (int a = 0; a < 65536; a++) mem[a] = 16'hDEAD;
      bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_nnz = '0; bus.i_len = '0;
      bus.i_ready = 1'b1;

      vt[0] = mk(16'h0100, 2, 6, 16'hAAAA, 1, 16'h5555, 4, 6,
                 {16'h0, 16'hAAAA, 16'h0, 16'h0, 16'h5555, 16'h0, 16'h0, 16'h0}, 0, 4, 0, 0);
      vt[1] = mk(16'h0400, 0, 3, 0, 0, 0, 0, 3, '0, 0, 0, 0, 0);
      vt[2] = mk(16'h0400, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, 0);
      vt[3] = vt[0];
      vt[3].stall = 1'b1;
      vt[4] = mk(16'hFFFE, 2, 4, 16'h1111, 0, 16'h2222, 3, 4,
                 {16'h1111, 16'h0, 16'h0, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0}, 0, 4, 0, 0);
      vt[5] = mk(16'h0200, 2, 5, 16'h7777, 3, 16'h8888, 2, 5,
                 {16'h0, 16'h0, 16'h0, 16'h7777, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 4, 0, 0);
      vt[6] = mk(16'h0300, 2, 4, 16'h00BB, 1, 16'h00CC, 7, 4,
                 {16'h0, 16'h00BB, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1, 4, 0, 1);
      vt[7] = mk(16'h0500, 1, 2, 16'h0000, 0, 0, 0, 2, '0, 0, 2, 0, 0);
      vt[8] = mk(16'h0600, 2, 0, 16'h1234, 0, 16'h5678, 1, 0, '0, 0, 0, 0, 0);

      repeat (3) @(posedge clk);
      #2;
      chk("rst_rd_en",   32'(bus.o_rd_en),   32'd0);
      chk("rst_rd_addr", 32'(bus.o_rd_addr), 32'd0);
      chk("rst_valid",   32'(bus.o_valid),   32'd0);
      chk("rst_data",    32'(bus.o_data),    32'd0);
      chk("rst_busy",    32'(bus.o_busy),    32'd0);
      chk("rst_done",    32'(bus.o_done),    32'd0);
      chk("rst_err",     32'(bus.o_err),     32'd0);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vt[i], i);

      // Reset while the offset word of the first pair is being read.
      load_pairs(vt[0]);
      clear_mon();
      do_start(vt[0].base, vt[0].nnz, vt[0].len);
      found = 1'b0;
      t = 0;
      while (!found && t < 20) begin
         @(negedge clk);
         if (bus.o_rd_en && bus.o_rd_addr == 16'h0101) found = 1'b1;
         t++;
      end
      chk("mid_rst_reached_rd_off", 32'(found), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_rd_en", 32'(bus.o_rd_en), 32'd0);
      chk("mid_rst_busy",  32'(bus.o_busy),  32'd0);
      chk("mid_rst_addr",  32'(bus.o_rd_addr), 32'd0);
      chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
      repeat (3) @(posedge clk);
      #2;
      chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
      rst = 1'b1;
      run_vec(vt[0], 9);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
